// File: rtl/weapons_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weapons_pkg
// Description : Shared constants and FSM state encoding for the weapons
//               trigger sequencer and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package weapons_pkg;

  // Ship mode code that permits firing
  localparam logic [3:0] MODE_ATTACK = 4'b0010;

  // Default width of ammo_level / fire_rate
  localparam int AMMO_W_DEF = 9;

  // Trigger sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_OVERHEAT = 2'd3
  } fc_state_t;

endpackage
`default_nettype wire

// File: rtl/heat_gauge.sv
`default_nettype none
// ============================================================================
// Module      : heat_gauge
// Description : Saturating heat counter. A shot adds HEAT_PER_SHOT (clamped
//               at HEAT_MAX); decay removes one unit per cycle (clamped at 0).
// Revision    : 1.0 - initial release
// ============================================================================
module heat_gauge #(
  parameter int HEAT_W        = 5,
  parameter int HEAT_PER_SHOT = 4,
  parameter int HEAT_MAX      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add,
  input  logic              decay,
  output logic [HEAT_W-1:0] heat,
  output logic              at_max,
  output logic              at_zero,
  output logic              add_saturates
);

  localparam logic [HEAT_W:0]   c_max_ext   = (HEAT_W+1)'(HEAT_MAX);
  localparam logic [HEAT_W:0]   c_shot_ext  = (HEAT_W+1)'(HEAT_PER_SHOT);
  localparam logic [HEAT_W-1:0] c_max       = HEAT_W'(HEAT_MAX);
  localparam logic [HEAT_W-1:0] c_one       = HEAT_W'(1);

  logic [HEAT_W-1:0] heat_q;
  logic [HEAT_W-1:0] heat_d;
  logic [HEAT_W:0]   w_sum;
  logic [HEAT_W:0]   w_sum_sat;

  // Next heat: an add has priority over decay; one extra bit avoids wrap
  always_comb begin
    w_sum     = {1'b0, heat_q} + c_shot_ext;
    w_sum_sat = (w_sum >= c_max_ext) ? c_max_ext : w_sum;
    heat_d    = heat_q;
    if (add) begin
      heat_d = w_sum_sat[HEAT_W-1:0];
    end else if (decay && (heat_q != '0)) begin
      heat_d = heat_q - c_one;
    end
  end

  // Heat register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heat_q <= '0;
    end else begin
      heat_q <= heat_d;
    end
  end

  assign heat          = heat_q;
  assign at_max        = (heat_q == c_max);
  assign at_zero       = (heat_q == '0);
  assign add_saturates = (w_sum_sat == c_max_ext);

endmodule
`default_nettype wire

// File: rtl/fire_control.sv
`default_nettype none
// ============================================================================
// Module      : fire_control
// Description : Trigger sequencer ahead of the ammo counter. Converts pilot
//               trigger edges into paced single or burst fire strobes, with
//               cooldown, overheat lockout and illegal-trigger flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module fire_control
  import weapons_pkg::*;
#(
  parameter int AMMO_W        = AMMO_W_DEF,
  parameter int COOLDOWN      = 4,
  parameter int BURST_LEN     = 3,
  parameter int ROUND_COST    = 1,
  parameter int HEAT_W        = 5,
  parameter int HEAT_PER_SHOT = 4,
  parameter int HEAT_MAX      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode_selector,
  input  logic              trigger,
  input  logic              burst_sel,
  input  logic [AMMO_W-1:0] ammo_level,
  input  logic              loading,
  output logic              fire,
  output logic [AMMO_W-1:0] fire_rate,
  output logic              busy,
  output logic              overheat,
  output logic [HEAT_W-1:0] heat,
  output logic              error
);

  localparam logic [AMMO_W-1:0] c_round_cost = AMMO_W'(ROUND_COST);
  localparam logic [2:0]        c_burst_m1   = 3'(BURST_LEN - 1);
  localparam logic [3:0]        c_cd_m1      = 4'(COOLDOWN - 1);
  localparam logic [HEAT_W-1:0] c_heat_one   = HEAT_W'(1);

  fc_state_t         state_q, state_d;
  logic              trig_q, trig_d;
  logic [2:0]        shots_left_q, shots_left_d;
  logic [3:0]        cd_cnt_q, cd_cnt_d;
  logic [AMMO_W-1:0] fire_rate_q, fire_rate_d;
  logic              error_q, error_d;

  logic              rise;
  logic              ok;
  logic [AMMO_W-1:0] rate_clamp;
  logic              heat_add;
  logic              heat_decay;
  logic [HEAT_W-1:0] heat_w;
  logic              heat_at_max;
  logic              heat_at_zero;
  logic              heat_add_sat;

  heat_gauge #(
    .HEAT_W        (HEAT_W),
    .HEAT_PER_SHOT (HEAT_PER_SHOT),
    .HEAT_MAX      (HEAT_MAX)
  ) u_heat_gauge (
    .clk           (clk),
    .rst_n         (rst),
    .add           (heat_add),
    .decay         (heat_decay),
    .heat          (heat_w),
    .at_max        (heat_at_max),
    .at_zero       (heat_at_zero),
    .add_saturates (heat_add_sat)
  );

  // Next-state, burst/cooldown bookkeeping and heat control
  always_comb begin
    rise         = trigger & ~trig_q;
    ok           = (mode_selector == MODE_ATTACK) & ~loading & (ammo_level != '0);
    rate_clamp   = (ammo_level < c_round_cost) ? ammo_level : c_round_cost;
    state_d      = state_q;
    trig_d       = trigger;
    shots_left_d = shots_left_q;
    cd_cnt_d     = cd_cnt_q;
    fire_rate_d  = fire_rate_q;
    error_d      = 1'b0;
    heat_add     = 1'b0;
    heat_decay   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        heat_decay = ~heat_at_zero;
        if (rise) begin
          if (ok) begin
            state_d      = ST_FIRE;
            shots_left_d = burst_sel ? c_burst_m1 : 3'd0;
            fire_rate_d  = rate_clamp;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      ST_FIRE: begin
        heat_add = 1'b1;
        // A gauge already pinned at the limit also counts as overheated
        if (heat_add_sat || heat_at_max) begin
          state_d      = ST_OVERHEAT;
          shots_left_d = 3'd0;
        end else begin
          state_d  = ST_COOLDOWN;
          cd_cnt_d = c_cd_m1;
        end
      end

      ST_COOLDOWN: begin
        // Losing permission mid-burst drops the remaining shots silently
        if (!ok) begin
          shots_left_d = 3'd0;
        end
        if (cd_cnt_q == 4'd0) begin
          if ((shots_left_q != 3'd0) && ok) begin
            state_d      = ST_FIRE;
            shots_left_d = shots_left_q - 3'd1;
            fire_rate_d  = rate_clamp;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cd_cnt_d = cd_cnt_q - 4'd1;
        end
      end

      ST_OVERHEAT: begin
        heat_decay = 1'b1;
        if (rise) begin
          error_d = 1'b1;
        end
        // Heat reaches zero on the same edge that leaves this state
        if (heat_w == c_heat_one) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      trig_q       <= 1'b0;
      shots_left_q <= 3'd0;
      cd_cnt_q     <= 4'd0;
      fire_rate_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      shots_left_q <= shots_left_d;
      cd_cnt_q     <= cd_cnt_d;
      fire_rate_q  <= fire_rate_d;
      error_q      <= error_d;
    end
  end

  assign fire      = (state_q == ST_FIRE);
  assign busy      = (state_q == ST_FIRE) || (state_q == ST_COOLDOWN);
  assign overheat  = (state_q == ST_OVERHEAT);
  assign fire_rate = fire_rate_q;
  assign heat      = heat_w;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: doc/fire_control.md
Name: fire_control

Overview:
- Trigger sequencer directly upstream of the weapons/ammo-counter stage.
- Turns pilot trigger input into paced 1-cycle fire pulses: single shot or fixed-length burst.
- Produces the per-shot round cost (fire_rate) for the ammo counter, clamped to the rounds remaining.
- Enforces cooldown between shots, a heat/overheat lockout, and flags illegal trigger attempts.

Parameters:
- AMMO_W, 9, width of ammo_level and fire_rate.
- COOLDOWN, 4, idle cycles forced after every shot (1..15).
- BURST_LEN, 3, shots per burst (1..7).
- ROUND_COST, 1, rounds consumed per shot before clamping.
- HEAT_W, 5, heat counter width.
- HEAT_PER_SHOT, 4, heat added per shot.
- HEAT_MAX, 15, saturation and overheat threshold.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- mode_selector  in  4  ship mode; 4'b0010 = attack.
- trigger  in  1  pilot trigger, level; only the rising edge is used.
- burst_sel  in  1  1 = burst mode, 0 = single shot; sampled on the trigger edge.
- ammo_level  in  AMMO_W  current count from the ammo counter.
- loading  in  1  reload in progress.
- fire  out  1  1-cycle shot strobe to the ammo counter.
- fire_rate  out  AMMO_W  rounds to deduct for the current shot.
- busy  out  1  high in FIRE or COOLDOWN.
- overheat  out  1  high in OVERHEAT.
- heat  out  HEAT_W  current heat value.
- error  out  1  1-cycle illegal-trigger pulse.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fire=0, fire_rate=0, busy=0, overheat=0, heat=0, error=0, trig_q=0, shots_left=0, cd_cnt=0.
- Edge detect: rise = trigger & ~trig_q; trig_q registers trigger every cycle.
- ok = (mode_selector==4'b0010) & ~loading & (ammo_level!=0).
- IDLE:
  - rise & ok -> FIRE; shots_left = burst_sel ? BURST_LEN-1 : 0.
  - rise & ~ok -> stay in IDLE; error=1 for the next cycle.
  - heat decrements by 1 per cycle while >0.
- FIRE: exactly 1 cycle; fire=1 (Moore output).
  - fire_rate = min(ROUND_COST, ammo_level), registered on entry and held until the next FIRE entry.
  - heat_next = min(heat+HEAT_PER_SHOT, HEAT_MAX).
  - heat_next==HEAT_MAX -> OVERHEAT; shots_left is cleared.
  - otherwise -> COOLDOWN with cd_cnt=COOLDOWN-1.
- COOLDOWN: lasts COOLDOWN cycles; heat holds.
  - At cd_cnt==0: if shots_left>0 and ok -> FIRE with shots_left-1; otherwise -> IDLE.
  - Abort: ~ok mid-burst (mode change, loading, ammo empty) clears shots_left. Cooldown still completes, then -> IDLE. No error is raised.
- OVERHEAT: heat decrements by 1 per cycle; -> IDLE when heat==1 (reaches 0 on the exit edge).
  - rise during OVERHEAT -> error pulse; the trigger is ignored.
- Trigger edges seen in FIRE/COOLDOWN are ignored; no queuing and no error.
- Latency: rise sampled at edge N -> fire high for cycle N+1. Burst shot period = 1+COOLDOWN cycles.
- Heat arithmetic saturates at 0 and HEAT_MAX; no wrap.
- error is registered, 1 cycle per offending rising edge.
- Reset mid-burst aborts immediately; no fire pulse after rst deasserts until a new rising edge.

Decomposition:
- Shared package weapons_pkg:
  - MODE_ATTACK = 4'b0010.
  - FSM state encoding IDLE/FIRE/COOLDOWN/OVERHEAT (2-bit).
  - AMMO_W default.
- Sub-module heat_gauge: saturating up/down counter.
  - Inputs: add pulse, decay enable.
  - Outputs: heat, at_max, at_zero.
- FSM, edge detect, burst/cooldown counters and fire_rate clamp live in fire_control.

Test Plan:
- Single shot: mode=0010, ammo=20, burst_sel=0, trigger 0->1 at edge 0 -> fire=1 in cycle 1 only; fire_rate=1; busy cycles 1-5; heat=4 at cycle 2, then decays to 0 in IDLE.
- Burst: burst_sel=1, ammo=20 -> fire in cycles 1, 6, 11; heat 4, 8, 12; IDLE at cycle 16.
- Overheat: burst to heat=12, then immediate single shot -> fire pulses, heat=15, overheat=1 for 15 cycles. A trigger edge during this window gives error=1 and no fire.
- Wrong mode / empty: mode=0001 with trigger edge -> error=1 one cycle, fire=0. mode=0010, ammo=0 -> same result.
- Mid-burst abort: start burst, assert loading during the first cooldown -> only 1 fire pulse; IDLE after 4 cooldown cycles; no error.
- Clamp and reset: ROUND_COST=5, ammo=3 -> fire_rate=3. Async rst low during a burst COOLDOWN -> all outputs 0 immediately; no fire after release until a new rising edge.
